// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared types for the multi-cycle MIPS memory responder:
//   - state_t : responder FSM states (IDLE, WAIT, RESP)
//   - op_t    : access kind latched at request acceptance
//   - WORD_BYTES : bytes per memory word (drives the word-index offset)
//   - decode_op  : maps the request strobes plus error flag onto an op_t
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_ERR   = 2'd3
  } op_t;

  // An error wins over everything; otherwise a write beats a simultaneous read.
  function automatic op_t decode_op(input logic rd, input logic wr, input logic err);
    op_t op;
    if (err) begin
      op = OP_ERR;
    end else if (wr) begin
      op = OP_WRITE;
    end else if (rd) begin
      op = OP_READ;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array
//   DEPTH x DATA_W word storage with a synchronous write port and a
//   synchronous, registered read port sharing one address.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous active-low reset (clears the read register only)
//     we     in   write enable, commits wdata to addr on the edge
//     re     in   read enable, captures mem[addr] into rdata on the edge
//     addr   in   word index
//     wdata  in   write data
//     rdata  out  registered read data, held while re is low
//   Storage contents are deliberately not reset.
module mem_word_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Word storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port; holds its value between enabled reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder
//   Memory-side responder for the multi-cycle MIPS datapath. A request
//   (memread/memwrite level) sampled in IDLE is accepted, held for
//   WAIT_CYCLES wait states, and completed with a one-cycle mem_ready pulse.
//   The array access happens on the edge that enters RESP.
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-low reset
//     memread    in   read request level
//     memwrite   in   write request level (wins over memread)
//     adr        in   byte address, word index = adr[log2(DEPTH)+1:2]
//     writedata  in   store data
//     readdata   out  load data, registered, held until the next completed read
//     mem_ready  out  one-cycle completion pulse
//     mem_err    out  one-cycle error pulse, coincident with mem_ready
//   Optional build macro MEM_RESP_ERR_EN: flags misaligned, out-of-range and
//   read+write-both-high requests as errors (no array access). Without it,
//   upper address bits wrap and mem_err stays 0.
module multicycle_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : {CW{1'b0}};

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r, cnt_nxt_s;
  logic [AW-1:0]     idx_r;
  logic [DATA_W-1:0] wdata_r;
  op_t               op_r;
  logic              mem_ready_r;
  logic              mem_err_r;

  logic              req_s;
  logic              err_s;
  op_t               live_op_s;
  op_t               acc_op_s;
  logic [AW-1:0]     acc_idx_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic              enter_resp_s;
  logic              we_s;
  logic              re_s;

  assign req_s = memread | memwrite;

`ifdef MEM_RESP_ERR_EN
  assign err_s = req_s &&
                 ((adr[OFF_W-1:0] != {OFF_W{1'b0}}) ||
                  (adr[ADDR_W-1:AW+OFF_W] != {(ADDR_W-AW-OFF_W){1'b0}}) ||
                  (memread && memwrite));
`else
  // Byte-offset and upper address bits play no part without error checking.
  logic unused_adr_s;
  assign err_s        = 1'b0;
  assign unused_adr_s = ^{adr[OFF_W-1:0], adr[ADDR_W-1:AW+OFF_W]};
`endif

  assign live_op_s = decode_op(memread, memwrite, err_s);

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          cnt_nxt_s = CNT_LOAD;
          if (NO_WAIT) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_r - CW'(1'b1);
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Access parameters: with zero wait states RESP is entered straight from
  // IDLE, so the live request must feed the array on the acceptance edge.
  always_comb begin
    acc_op_s    = op_r;
    acc_idx_s   = idx_r;
    acc_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      acc_op_s    = live_op_s;
      acc_idx_s   = adr[AW+OFF_W-1:OFF_W];
      acc_wdata_s = writedata;
    end else begin
      acc_op_s    = op_r;
      acc_idx_s   = idx_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Reset gates the write so an aborted access never commits.
  assign enter_resp_s = (state_nxt_s == RESP);
  assign we_s = reset && enter_resp_s && (acc_op_s == OP_WRITE);
  assign re_s = reset && enter_resp_s && (acc_op_s == OP_READ);

  // FSM state, counter, latched request and registered response flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      idx_r       <= {AW{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      op_r        <= OP_NONE;
      mem_ready_r <= 1'b0;
      mem_err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if ((state_r == IDLE) && req_s) begin
        idx_r   <= adr[AW+OFF_W-1:OFF_W];
        wdata_r <= writedata;
        op_r    <= live_op_s;
      end
      mem_ready_r <= enter_resp_s;
      mem_err_r   <= enter_resp_s && (acc_op_s == OP_ERR);
    end
  end

  mem_word_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .re    (re_s),
    .addr  (acc_idx_s),
    .wdata (acc_wdata_s),
    .rdata (readdata)
  );

  assign mem_ready = mem_ready_r;
  assign mem_err   = mem_err_r;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb_multicycle_mem_responder
//   Directed-vector bench for multicycle_mem_responder. Two instances:
//   u0 with WAIT_CYCLES=2 and u1 with WAIT_CYCLES=0. Each issued access
//   pushes its expected completion (cycle, readdata, mem_err) onto a
//   per-instance queue; a negedge monitor pops and compares on mem_ready.
//   Honours MEM_RESP_ERR_EN to select the error-checking vectors.
module tb_multicycle_mem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;
  localparam int DEPTH = 256;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] adr0, wd0, adr1, wd1;
  logic [31:0] readdata0, readdata1;
  logic        ready0, err0, ready1, err1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  multicycle_mem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W0)
  ) u0 (
    .clk(clk), .reset(reset), .memread(rd0), .memwrite(wr0), .adr(adr0),
    .writedata(wd0), .readdata(readdata0), .mem_ready(ready0), .mem_err(err0)
  );

  multicycle_mem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W1)
  ) u1 (
    .clk(clk), .reset(reset), .memread(rd1), .memwrite(wr1), .adr(adr1),
    .writedata(wd1), .readdata(readdata1), .mem_ready(ready1), .mem_err(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every mem_ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ready0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u0_unexpected_ready: mem_ready=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        m0 = q0.pop_front();
        chk("u0_ready_cycle", 32'(cyc), 32'(m0.cyc));
        chk("u0_readdata", readdata0, m0.rd);
        chk("u0_mem_err", {31'd0, err0}, {31'd0, m0.err});
      end
    end else if (err0) begin
      checks++;
      errors++;
      $display("FAIL u0_err_without_ready: mem_err=1 mem_ready=0 at cycle %0d, expected mem_err=0", cyc);
    end
    if (ready1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u1_unexpected_ready: mem_ready=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        m1 = q1.pop_front();
        chk("u1_ready_cycle", 32'(cyc), 32'(m1.cyc));
        chk("u1_readdata", readdata1, m1.rd);
        chk("u1_mem_err", {31'd0, err1}, {31'd0, m1.err});
      end
    end else if (err1) begin
      checks++;
      errors++;
      $display("FAIL u1_err_without_ready: mem_err=1 mem_ready=0 at cycle %0d, expected mem_err=0", cyc);
    end
  end

  // One access on the selected instance: strobe for one acceptance edge, then idle.
  task automatic access(input int dut, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    e.rd  = exp_rd;
    e.err = exp_err;
    if (dut == 0) begin
      rd0 = rd; wr0 = wr; adr0 = a; wd0 = d;
      e.cyc = cyc + 1 + W0;
      q0.push_back(e);
    end else begin
      rd1 = rd; wr1 = wr; adr1 = a; wd1 = d;
      e.cyc = cyc + 1 + W1;
      q1.push_back(e);
    end
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    repeat (W0 + 3) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0;
    rd0 = 1'b0; wr0 = 1'b0; adr0 = 32'h0; wd0 = 32'h0;
    rd1 = 1'b0; wr1 = 1'b0; adr1 = 32'h0; wd1 = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_readdata0", readdata0, 32'h0);
    chk("reset_ready0", {31'd0, ready0}, 32'h0);
    chk("reset_err0", {31'd0, err0}, 32'h0);
    chk("reset_readdata1", readdata1, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Basic write then read back with two wait states.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Read held through RESP and one IDLE cycle: two accesses, one IDLE gap.
    @(negedge clk);
    rd0 = 1'b1; adr0 = 32'h10;
    e.rd = 32'hDEADBEEF; e.err = 1'b0;
    e.cyc = cyc + 1 + W0;         q0.push_back(e);
    e.cyc = cyc + 1 + W0 + 2 + W0; q0.push_back(e);
    repeat (W0 + 3) @(negedge clk);
    rd0 = 1'b0;
    repeat (W0 + 4) @(negedge clk);

    // Known contents at 0x20, then a write there aborted by reset during WAIT.
    access(0, 1'b0, 1'b1, 32'h20, 32'h55AA0001, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    wr0 = 1'b1; adr0 = 32'h20; wd0 = 32'hAAAA5555;
    @(negedge clk);
    wr0 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_readdata0", readdata0, 32'h0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h55AA0001, 1'b0);

`ifdef MEM_RESP_ERR_EN
    // Misaligned, out-of-range and both-high accesses flag errors, no array effect.
    access(0, 1'b1, 1'b0, 32'h3, 32'h0, 32'h55AA0001, 1'b1);
    access(0, 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 32'h55AA0001, 1'b1);
    access(0, 1'b0, 1'b1, 32'h8, 32'hCAFE0008, 32'h55AA0001, 1'b0);
    access(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 32'h55AA0001, 1'b1);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'hCAFE0008, 1'b0);
`else
    // Byte offset ignored, both-high is a write, upper address bits wrap.
    access(0, 1'b0, 1'b1, 32'h14, 32'h01234567, 32'h55AA0001, 1'b0);
    access(0, 1'b1, 1'b0, 32'h17, 32'h0, 32'h01234567, 1'b0);
    access(0, 1'b1, 1'b1, 32'h24, 32'h0BADF00D, 32'h01234567, 1'b0);
    access(0, 1'b1, 1'b0, 32'h24, 32'h0, 32'h0BADF00D, 1'b0);
    access(0, 1'b0, 1'b1, 32'(DEPTH * 4 + 4), 32'h11111111, 32'h0BADF00D, 1'b0);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h11111111, 1'b0);
`endif

    // Zero wait states: response in the cycle right after acceptance.
    access(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);

    repeat (8) @(negedge clk);
    chk("u0_pending_responses", 32'(q0.size()), 32'h0);
    chk("u1_pending_responses", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_mem_responder.md
# multicycle_mem_responder

Memory-side responder for the multi-cycle MIPS datapath. Accepts the read/write strobes, address and write data issued by the controller/datapath, performs the access against an internal word array after a fixed number of wait states, and returns a one-cycle ready pulse with read data. It replaces the zero-latency memory model so that controller stalls can be exercised.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 32, byte-address width
- DEPTH, 256, number of words in the array (power of two)
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 legal)

- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- memread  input  1  read request level
- memwrite  input  1  write request level
- adr  input  ADDR_W  byte address (IorD-muxed)
- writedata  input  DATA_W  store data
- readdata  output  DATA_W  load data, registered, held between reads
- mem_ready  output  1  one-cycle completion pulse
- mem_err  output  1  one-cycle error pulse, coincident with mem_ready

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if memread or memwrite is sampled high at an edge, latch adr, writedata and op; go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0). Wait counter loads WAIT_CYCLES-1.
- WAIT: decrement counter; at 0 go to RESP. Request inputs ignored.
- RESP: mem_ready=1 for exactly this cycle; next state IDLE unconditionally.
- Write committed to array on the edge entering RESP; visible to any later read.
- Read: array word captured into readdata on the edge entering RESP; readdata held until next completed read (writes and errors do not change it).
- Word index = adr[log2(DEPTH)+1:2]; adr[1:0] ignored for indexing.
- memread and memwrite both high at acceptance: write priority (no read performed).
- Initiator must drop the request in the cycle after mem_ready; a level still high in IDLE is a new access.

## Timing
- Request accepted at edge k -> RESP cycle is k+1+WAIT_CYCLES; mem_ready high only in that cycle.
- Back-to-back: earliest next acceptance is the edge ending RESP+1 (one IDLE cycle minimum).
- Reset (reset=0 at an edge): state IDLE, counter 0, readdata 0, mem_ready 0, mem_err 0. Array contents not reset.
- Reset mid-operation: access aborted; a pending write not yet in RESP is never committed; no mem_ready.

## Configuration
- Macro MEM_RESP_ERR_EN.
- Defined: at acceptance, adr[1:0]!=0 or adr >= DEPTH*4 flags error, as does memread&memwrite both high. Flagged access performs no array read or write, readdata unchanged; mem_err=1 together with mem_ready in RESP. Latency identical to a normal access.
- Not defined: no checking; upper address bits wrap, both-high is write priority; mem_err tied 0.

## Structure
- Package mem_resp_pkg: state enum (IDLE, WAIT, RESP), WORD_BYTES=4 constant, op encoding.
- One sub-module, mem_word_array: DEPTH x DATA_W storage, synchronous write enable, synchronous registered read; FSM and counter stay in the top.

## Test plan
- WAIT_CYCLES=2: write 0xDEADBEEF to adr 0x10 accepted at edge 0 -> mem_ready only in cycle 3; subsequent read of 0x10 returns readdata=0xDEADBEEF with mem_ready 3 cycles after acceptance.
- WAIT_CYCLES=0: read of adr 0x0 after write 0x12345678 -> mem_ready in the cycle right after acceptance, readdata=0x12345678.
- Request held high through RESP and one extra cycle -> exactly two accesses, two mem_ready pulses separated by an IDLE cycle.
- Write 0xAAAA5555 to 0x20, reset asserted during WAIT -> no mem_ready; read 0x20 afterwards returns prior contents, readdata=0 immediately after reset.
- With MEM_RESP_ERR_EN: read adr 0x3 and adr DEPTH*4 -> mem_ready+mem_err together, readdata unchanged; memread&memwrite both high to 0x8 -> error, word 0x8 unchanged.
- Without MEM_RESP_ERR_EN: write 0x11111111 to adr DEPTH*4+4 -> word 1 updated; mem_err stays 0.
